pcileech_sysctl: RTL

//  Parametrised system-control block for all board top levels: power-on reset stretching, free-running

---
 rtl/pcileech_sysctl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pcileech_sysctl.sv
// System control: power-on reset stretch, tick counter, debounced buttons with
// press / long-press detection, and per-LED drive modes.
module pcileech_sysctl #(
   parameter int unsigned NUM_BTN         = 2,
   parameter int unsigned NUM_LED         = 2,
   parameter int unsigned CNT_WIDTH       = 64,
   parameter int unsigned RST_HOLD_CYCLES = 64,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 500000000,
   parameter bit          RST_BTN_EN      = 1'b1,
   parameter int unsigned RST_BTN_IDX     = 1,
   parameter int unsigned BLINK_BIT       = 24,
   parameter int unsigned PWRON_BIT       = 27
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BTN-1:0]     btn_n,
   input  logic [NUM_LED-1:0]     led_in,
   input  logic [2*NUM_LED-1:0]   led_mode,
   output logic                   rst_out,
   output logic [CNT_WIDTH-1:0]   tickcount,
   output logic [NUM_BTN-1:0]     btn_state,
   output logic [NUM_BTN-1:0]     btn_press,
   output logic [NUM_BTN-1:0]     btn_long,
   output logic [NUM_BTN-1:0]     btn_long_lvl,
   output logic [NUM_LED-1:0]     led_out
);

   localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] POR_LAST = CNT_WIDTH'(RST_HOLD_CYCLES - 1);

   logic [NUM_BTN-1:0]             sync1_q, sync2_q;
   logic [NUM_BTN-1:0]             state_q, state_d;
   logic [NUM_BTN-1:0]             press_q, press_d;
   logic [NUM_BTN-1:0]             long_q, long_d;
   logic [NUM_BTN-1:0]             lvl_q, lvl_d;
   logic [NUM_BTN-1:0][DEB_W-1:0]  deb_q, deb_d;
   logic [NUM_BTN-1:0][HOLD_W-1:0] hold_q, hold_d;

   logic [CNT_WIDTH-1:0]           tick_q, tick_d;
   logic                           por_q, por_d;
   logic                           rst_out_q, rst_out_d;
   logic [NUM_LED-1:0]             led_q, led_d;

   logic                           sys_clr;
   logic                           blink, pwron;

   // Button path: a level must differ from the debounced state for
   // DEBOUNCE_CYCLES consecutive samples before the state follows it.
   always_comb begin
      state_d = state_q;
      deb_d   = deb_q;
      hold_d  = hold_q;
      press_d = '0;
      long_d  = '0;
      lvl_d   = '0;
      for (int i = 0; i < int'(NUM_BTN); i++) begin
         if (~sync2_q[i] != state_q[i]) begin
            if (deb_q[i] == DEB_LAST) begin
               state_d[i] = ~state_q[i];
               deb_d[i]   = '0;
            end else begin
               deb_d[i] = deb_q[i] + 1'b1;
            end
         end else begin
            deb_d[i] = '0;
         end
         press_d[i] = state_d[i] & ~state_q[i];

         if (!state_q[i]) begin
            hold_d[i] = '0;
         end else if (hold_q[i] != HOLD_MAX) begin
            hold_d[i] = hold_q[i] + 1'b1;
         end
         long_d[i] = state_q[i] & (hold_q[i] == HOLD_PRE);
         lvl_d[i]  = (long_d[i] | lvl_q[i]) & state_d[i];
      end
   end

   // The reset button only clears the system side; button logic obeys rst alone.
   assign sys_clr = rst | (RST_BTN_EN && state_q[RST_BTN_IDX]);

   always_comb begin
      tick_d    = sys_clr ? '0 : tick_q + 1'b1;
      por_d     = ~sys_clr & (por_q | (tick_q == POR_LAST));
      rst_out_d = sys_clr | ~por_d;
   end

   assign blink = tick_q[BLINK_BIT];
   assign pwron = blink & ~(|tick_q[CNT_WIDTH-1:PWRON_BIT]);

   always_comb begin
      led_d = '0;
      for (int i = 0; i < int'(NUM_LED); i++) begin
         case (led_mode[2*i +: 2])
            2'b00:   led_d[i] = led_in[i];
            2'b01:   led_d[i] = ~led_in[i];
            2'b10:   led_d[i] = led_in[i] & blink;
            default: led_d[i] = led_in[i] ^ pwron;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         state_q   <= '0;
         press_q   <= '0;
         long_q    <= '0;
         lvl_q     <= '0;
         deb_q     <= '0;
         hold_q    <= '0;
         tick_q    <= '0;
         por_q     <= 1'b0;
         rst_out_q <= 1'b1;
         led_q     <= '0;
      end else begin
         sync1_q   <= btn_n;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         press_q   <= press_d;
         long_q    <= long_d;
         lvl_q     <= lvl_d;
         deb_q     <= deb_d;
         hold_q    <= hold_d;
         tick_q    <= tick_d;
         por_q     <= por_d;
         rst_out_q <= rst_out_d;
         led_q     <= led_d;
      end
   end

   assign rst_out      = rst_out_q;
   assign tickcount    = tick_q;
   assign btn_state    = state_q;
   assign btn_press    = press_q;
   assign btn_long     = long_q;
   assign btn_long_lvl = lvl_q;
   assign led_out      = led_q;

endmodule
